pin_entry: RTL and testbench
============================

PIN_ENTRY -- requirements
Module: pin_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, cycles without an accepted key before an entry aborts.
REQ-002 SHALL have parameter MAX_DIGITS, default 3, maximum decimal digits per entry.
REQ-003 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port senr_e  in  1  entry sensor; 1 = vehicle present at entry gate.
REQ-006 SHALL have port key_vld  in  1  one-cycle keypad strobe qualifying key_code.
REQ-007 SHALL have port key_code  in  4  0-9 digit; 4'hA CLR; 4'hB ENT; 4'hC-4'hF ignored.
REQ-008 SHALL have port pin  out  8  last committed PIN as a level, consumed by parking controller.
REQ-009 SHALL have port pin_vld  out  1  one-cycle pulse when pin is updated.
REQ-010 SHALL have port entry_busy  out  1  high while in ENTRY state.
REQ-011 SHALL have port entry_err  out  1  one-cycle pulse on a rejected or timed-out entry.

Function
REQ-012 SHALL implement FSM states IDLE, ENTRY, DONE, ERR.
REQ-013 IDLE: senr_e=1 -> ENTRY next cycle; accumulator, digit count and timer cleared.
REQ-014 ENTRY digit d: if count==MAX_DIGITS or acc*10+d>255 -> ERR; else acc<=acc*10+d, count++ .
REQ-015 Accumulator SHALL be 10 bits wide so acc*10+d is computed without wrap before the >255 compare.
REQ-016 ENTRY CLR: acc=0, count=0, timer=0, stay in ENTRY, no pulse.
REQ-017 ENTRY ENT with count==0 -> ERR; otherwise pin<=acc[7:0], pin_vld=1 in the next cycle, -> DONE.
REQ-018 Codes 4'hC-4'hF SHALL be ignored entirely; they do not restart the timer.
REQ-019 Timer SHALL count cycles in ENTRY, clear on every accepted key, and at TIMEOUT_CYC-1 -> ERR.
REQ-020 ERR: entry_err=1 for exactly one cycle; acc/count cleared; next state ENTRY if senr_e=1, else IDLE.
REQ-021 DONE: senr_e=0 -> IDLE; digit key -> ENTRY with acc=d, count=1 (re-entry after rejected PIN); CLR/ENT ignored.
REQ-022 senr_e falling in ENTRY SHALL abort to IDLE with no entry_err and pin unchanged.
REQ-023 Simultaneous events: senr_e=0 beats key_vld; accepted key_vld beats timeout.
REQ-024 pin SHALL hold its value until the next commit or reset; pin_vld and entry_err never both high.

Reset
REQ-025 On reset=1 at a clock edge: state=IDLE, pin=8'd0, pin_vld=0, entry_busy=0, entry_err=0, acc/count/timer=0.
REQ-026 Reset asserted mid-entry SHALL discard the partial entry with no pulses on the following cycle.

Structure
REQ-027 Key codes (CLR, ENT) and the FSM state encoding SHALL live in shared package parking_pkg.
REQ-028 The timeout counter SHALL be a sub-module entry_timer (clear, enable, expired), parameterised by TIMEOUT_CYC.
REQ-029 Total RTL SHALL be roughly 150-250 lines.

Verification
REQ-030 reset, senr_e=1, keys 7,1,ENT -> pin=8'd71, pin_vld high exactly one cycle after ENT sampled.
REQ-031 keys 2,5,6 -> entry_err the cycle after 6; then 2,5,5,ENT -> pin=8'd255.
REQ-032 keys 1,2,3,4 (MAX_DIGITS=3) -> entry_err after 4; ENT with no digits -> entry_err, no pin_vld.
REQ-033 TIMEOUT_CYC=20: key 5 then 20 idle cycles -> one entry_err, pin unchanged; key 12 in gap does not extend timeout.
REQ-034 keys 9,CLR,3,ENT -> pin=8'd3; then key 4 in DONE, senr_e=0 -> IDLE, no entry_err, pin stays 3.
REQ-035 reset asserted after key 8 -> all outputs zero the next cycle; entry restarts only on senr_e=1.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared keypad codes and entry-FSM state encoding for the parking gate.
package parking_pkg;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_ENT = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Digits 0-9; CLR/ENT and the unused codes above them are not digits.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity timer for PIN entry. Down-counter loaded with TIMEOUT_CYC-1,
// so expired asserts on the TIMEOUT_CYC-th enabled cycle after a clear.
module entry_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    // Reload on clear, otherwise count down while enabled and hold at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else if (clear) begin
            cnt_q <= LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/pin_entry.sv
// Keypad PIN entry for the parking entry gate. Accumulates up to MAX_DIGITS
// decimal digits (value <= 255) and commits on ENT.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no vehicle; waiting for senr_e
//   ST_ENTRY | vehicle present, collecting digits (entry_busy high)
//   ST_DONE  | PIN committed; a digit restarts entry, senr_e low -> idle
//   ST_ERR   | rejected or timed-out entry; entry_err high for this cycle
module pin_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_DIGITS  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       senr_e,
    input  logic       key_vld,
    input  logic [3:0] key_code,
    output logic [7:0] pin,
    output logic       pin_vld,
    output logic       entry_busy,
    output logic       entry_err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t           state_q;
    logic [9:0]       acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       pin_q;
    logic             pin_vld_q;
    logic             busy_q;
    logic             err_q;

    logic             key_acc;
    logic             key_dig;
    logic [11:0]      acc_d;
    logic             digit_reject;
    logic             tmr_clear;
    logic             tmr_expired;

    // Codes C-F are not keys at all: they neither act nor restart the timer.
    assign key_acc = key_vld && (key_code <= KEY_ENT);
    assign key_dig = key_vld && is_digit(key_code);

    // Widened so acc*10+d cannot wrap before the range check.
    assign acc_d        = ({2'b00, acc_q} * 12'd10) + {8'd0, key_code};
    assign digit_reject = (cnt_q == CNT_W'(MAX_DIGITS)) || (acc_d > 12'd255);

    assign tmr_clear = (state_q != ST_ENTRY) || key_acc;

    entry_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (state_q == ST_ENTRY),
        .expired(tmr_expired)
    );

    // Entry FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            pin_q     <= '0;
            pin_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pin_vld_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (senr_e) begin
                        state_q <= ST_ENTRY;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_ENTRY: begin
                    if (!senr_e) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (key_acc) begin
                        if (key_code == KEY_CLR) begin
                            acc_q <= '0;
                            cnt_q <= '0;
                        end else if (key_code == KEY_ENT) begin
                            busy_q <= 1'b0;
                            if (cnt_q == '0) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q   <= ST_DONE;
                                pin_q     <= acc_q[7:0];
                                pin_vld_q <= 1'b1;
                            end
                        end else if (digit_reject) begin
                            state_q <= ST_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            acc_q <= acc_d[9:0];
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (tmr_expired) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_DONE: begin
                    if (!senr_e) begin
                        state_q <= ST_IDLE;
                    end else if (key_dig) begin
                        // Driver retyping after a rejected PIN: the digit counts.
                        state_q <= ST_ENTRY;
                        busy_q  <= 1'b1;
                        acc_q   <= {6'd0, key_code};
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (senr_e) begin
                        state_q <= ST_ENTRY;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pin        = pin_q;
    assign pin_vld    = pin_vld_q;
    assign entry_busy = busy_q;
    assign entry_err  = err_q;

endmodule

// File: tb/tb_pin_entry.sv
// Bench for pin_entry: directed scenarios followed by random keypad traffic,
// every cycle compared against a digit-list reference model.
module tb_pin_entry;

    localparam int TO = 20;
    localparam int MD = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       senr_e;
    logic       key_vld;
    logic [3:0] key_code;
    logic [7:0] pin;
    logic       pin_vld;
    logic       entry_busy;
    logic       entry_err;

    pin_entry #(
        .TIMEOUT_CYC(TO),
        .MAX_DIGITS (MD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .senr_e    (senr_e),
        .key_vld   (key_vld),
        .key_code  (key_code),
        .pin       (pin),
        .pin_vld   (pin_vld),
        .entry_busy(entry_busy),
        .entry_err (entry_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the driver has typed so far, how long since the
    // last real key, and which phase of the gate interaction we are in.
    typedef enum int {M_IDLE, M_TYPING, M_COMMITTED, M_REJECTED} phase_t;
    phase_t phase = M_IDLE;
    int     digs[$];
    int     quiet = 0;
    int     e_pin = 0, e_vld = 0, e_busy = 0, e_err = 0;
    logic   s_senr = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int typed_value();
        int v = 0;
        foreach (digs[i]) v = v * 10 + digs[i];
        return v;
    endfunction

    function automatic void reject();
        phase = M_REJECTED;
        e_err = 1;
        digs.delete();
    endfunction

    function automatic void model_step(input logic r, input logic s, input logic v, input int c);
        if (r) begin
            phase = M_IDLE;
            digs.delete();
            quiet = 0;
            e_pin = 0; e_vld = 0; e_busy = 0; e_err = 0;
            return;
        end
        e_vld = 0;
        e_err = 0;
        case (phase)
            M_IDLE: if (s) begin phase = M_TYPING; digs.delete(); quiet = 0; end
            M_TYPING: begin
                if (!s) phase = M_IDLE;
                else if (v && c <= 11) begin
                    quiet = 0;
                    if (c == 10) digs.delete();
                    else if (c == 11) begin
                        if (digs.size() == 0) reject();
                        else begin e_pin = typed_value(); e_vld = 1; phase = M_COMMITTED; end
                    end else if (digs.size() >= MD || typed_value() * 10 + c > 255) reject();
                    else digs.push_back(c);
                end else begin
                    quiet++;
                    if (quiet == TO) reject();
                end
            end
            M_COMMITTED: begin
                if (!s) phase = M_IDLE;
                else if (v && c <= 9) begin
                    phase = M_TYPING; digs.delete(); digs.push_back(c); quiet = 0;
                end
            end
            M_REJECTED: begin
                digs.delete();
                quiet = 0;
                phase = s ? M_TYPING : M_IDLE;
            end
            default: phase = M_IDLE;
        endcase
        e_busy = (phase == M_TYPING) ? 1 : 0;
    endfunction

    // One clock: drive, let DUT and model see the edge, compare on the falling edge.
    task automatic tick(input logic r, input logic v, input logic [3:0] c);
        reset    = r;
        senr_e   = s_senr;
        key_vld  = v;
        key_code = c;
        @(posedge clock);
        model_step(r, s_senr, v, int'(c));
        @(negedge clock);
        chk("pin", int'(pin), e_pin);
        chk("pin_vld", int'(pin_vld), e_vld);
        chk("entry_busy", int'(entry_busy), e_busy);
        chk("entry_err", int'(entry_err), e_err);
        chk("vld_err_excl", int'(pin_vld & entry_err), 0);
    endtask

    task automatic key(input logic [3:0] c);
        tick(1'b0, 1'b1, c);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        int   errs;
        int   kprob;
        logic r, v;
        logic [3:0] c;

        // Reset state
        s_senr = 1'b0;
        tick(1'b1, 1'b0, 4'd0);
        chk("rst_pin", int'(pin), 0);
        chk("rst_busy", int'(entry_busy), 0);

        // 7,1,ENT -> 71
        s_senr = 1'b1;
        idle();
        chk("busy_on", int'(entry_busy), 1);
        key(4'd7);
        key(4'd1);
        key(4'hB);
        chk("pin71", int'(pin), 71);
        chk("vld71", int'(pin_vld), 1);
        idle();
        chk("vld71_once", int'(pin_vld), 0);

        // 2,5,6 overflows; 2,5,5,ENT -> 255
        key(4'd2);
        key(4'd5);
        key(4'd6);
        chk("err256", int'(entry_err), 1);
        idle();
        key(4'd2);
        key(4'd5);
        key(4'd5);
        key(4'hB);
        chk("pin255", int'(pin), 255);
        chk("vld255", int'(pin_vld), 1);

        // Too many digits, then ENT with nothing typed
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        chk("err_4dig", int'(entry_err), 1);
        idle();
        key(4'hB);
        chk("err_empty", int'(entry_err), 1);
        chk("vld_empty", int'(pin_vld), 0);

        // Timeout: code C in the gap must not restart the timer
        idle();
        key(4'd5);
        errs = 0;
        for (int i = 1; i <= TO; i++) begin
            if (i == 10) key(4'hC);
            else idle();
            if (entry_err) errs++;
            if (i == TO - 1) chk("to_early", int'(entry_err), 0);
        end
        chk("to_fire", int'(entry_err), 1);
        chk("to_count", errs, 1);
        chk("to_pin", int'(pin), 255);

        // 9,CLR,3,ENT -> 3; digit in DONE then vehicle leaves
        idle();
        key(4'd9);
        key(4'hA);
        chk("clr_no_err", int'(entry_err), 0);
        key(4'd3);
        key(4'hB);
        chk("pin3", int'(pin), 3);
        key(4'd4);
        chk("reentry_busy", int'(entry_busy), 1);
        s_senr = 1'b0;
        idle();
        chk("leave_busy", int'(entry_busy), 0);
        chk("leave_err", int'(entry_err), 0);
        chk("leave_pin", int'(pin), 3);

        // Reset mid-entry
        s_senr = 1'b1;
        idle();
        key(4'd8);
        s_senr = 1'b0;
        tick(1'b1, 1'b0, 4'd0);
        chk("mid_rst_pin", int'(pin), 0);
        chk("mid_rst_vld", int'(pin_vld), 0);
        chk("mid_rst_busy", int'(entry_busy), 0);
        chk("mid_rst_err", int'(entry_err), 0);
        for (int i = 0; i < 3; i++) idle();
        chk("no_restart", int'(entry_busy), 0);
        s_senr = 1'b1;
        idle();
        chk("restart", int'(entry_busy), 1);

        // Random traffic with varying key density
        for (int blk = 0; blk < 30; blk++) begin
            case ($urandom_range(0, 2))
                0:       kprob = 50;
                1:       kprob = 12;
                default: kprob = 3;
            endcase
            for (int i = 0; i < 100; i++) begin
                if (s_senr) begin
                    if ($urandom_range(0, 59) == 0) s_senr = 1'b0;
                end else begin
                    if ($urandom_range(0, 7) == 0) s_senr = 1'b1;
                end
                r = ($urandom_range(0, 199) == 0);
                v = ($urandom_range(0, 99) < kprob);
                c = 4'($urandom_range(0, 15));
                tick(r, v, c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
